// File: rtl/qdec_pkg.sv
// Shared types, phase/direction constants and the transition classifier for quad_decoder_x4.
package qdec_pkg;

  typedef enum logic {QD_INIT, QD_TRACK} qd_state_t;

  typedef enum logic [1:0] {QD_NONE, QD_UP, QD_DN, QD_ILL} qd_move_t;

  localparam logic [1:0] QD_PH00 = 2'b00;
  localparam logic [1:0] QD_PH01 = 2'b01;
  localparam logic [1:0] QD_PH11 = 2'b11;
  localparam logic [1:0] QD_PH10 = 2'b10;

  localparam logic QD_DIR_UP = 1'b0;
  localparam logic QD_DIR_DN = 1'b1;

  // Phases are packed {A,B}; up order is 00->01->11->10->00.
  function automatic qd_move_t qd_decode(input logic [1:0] prev, input logic [1:0] cur);
    qd_move_t m;
    m = QD_NONE;
    case ({prev, cur})
      {QD_PH00, QD_PH01}, {QD_PH01, QD_PH11},
      {QD_PH11, QD_PH10}, {QD_PH10, QD_PH00}: m = QD_UP;
      {QD_PH00, QD_PH10}, {QD_PH10, QD_PH11},
      {QD_PH11, QD_PH01}, {QD_PH01, QD_PH00}: m = QD_DN;
      {QD_PH00, QD_PH11}, {QD_PH11, QD_PH00},
      {QD_PH01, QD_PH10}, {QD_PH10, QD_PH01}: m = QD_ILL;
      default: m = QD_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/quad_decoder_x4_if.sv
// Encoder-side and count-side signals of quad_decoder_x4; slave is the decoder, master the driver.
interface quad_decoder_x4_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             quad_a;
  logic             quad_b;
  logic             quad_i;
  logic             err_clr;
  logic [CNT_W-1:0] count;
  logic             dir;
  logic             step;
  logic             err;

  modport master (output en, quad_a, quad_b, quad_i, err_clr,
                  input  count, dir, step, err);
  modport slave  (input  en, quad_a, quad_b, quad_i, err_clr,
                  output count, dir, step, err);
endinterface

// File: rtl/qdec_sync_filter.sv
// Per-pin synchronizer chain followed by a debounce filter that only follows
// the synced value after FILT_LEN consecutive identical samples.
module qdec_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_dout;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign dout     = r_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  // r_cnt counts consecutive samples that disagree with the current output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_dout <= 1'b0;
    end else if (w_synced == r_dout) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt  <= '0;
      r_dout <= w_synced;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/quad_decoder_x4.sv
// x4 quadrature decoder: synced/filtered A/B phases drive an up/down position counter.
// Optional index clear is built only when QDEC_INDEX_CLR_EN is defined.
module quad_decoder_x4
  import qdec_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input logic               clk,
  input logic               rst,
  quad_decoder_x4_if.slave  bus
);

  // INIT keeps following the filtered phase until the input pipeline has flushed
  // its reset zeros, so a non-00 phase present at reset release is not an error.
  localparam int INIT_LAST_I = SYNC_STAGES + FILT_LEN;
  localparam int IW          = $clog2(INIT_LAST_I + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_LAST_I);

  qd_state_t        r_state;
  logic [IW-1:0]    r_init_cnt;
  logic [1:0]       r_prev_ab;
  logic [CNT_W-1:0] r_count;
  logic             r_dir;
  logic             r_step;
  logic             r_err;
  logic             w_a;
  logic             w_b;
  logic [1:0]       w_ab;
  qd_move_t         w_move;

  qdec_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk (clk), .rst (rst), .din (bus.quad_a), .dout (w_a)
  );

  qdec_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk (clk), .rst (rst), .din (bus.quad_b), .dout (w_b)
  );

`ifdef QDEC_INDEX_CLR_EN
  logic w_idx;
  logic r_idx_prev;

  qdec_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_i (
    .clk (clk), .rst (rst), .din (bus.quad_i), .dout (w_idx)
  );
`endif

  assign w_ab   = {w_a, w_b};
  assign w_move = qd_decode(r_prev_ab, w_ab);

  assign bus.count = r_count;
  assign bus.dir   = r_dir;
  assign bus.step  = r_step;
  assign bus.err   = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= QD_INIT;
      r_init_cnt <= '0;
      r_prev_ab  <= QD_PH00;
      r_count    <= '0;
      r_dir      <= QD_DIR_UP;
      r_step     <= 1'b0;
      r_err      <= 1'b0;
`ifdef QDEC_INDEX_CLR_EN
      r_idx_prev <= 1'b0;
`endif
    end else begin
      r_step    <= 1'b0;
      r_prev_ab <= w_ab;
      if (bus.err_clr) r_err <= 1'b0;
      case (r_state)
        QD_INIT: begin
          if (r_init_cnt == INIT_LAST) r_state <= QD_TRACK;
          else r_init_cnt <= r_init_cnt + 1'b1;
        end
        QD_TRACK: begin
          case (w_move)
            QD_UP: if (bus.en) begin
              r_count <= r_count + CNT_W'(1);
              r_dir   <= QD_DIR_UP;
              r_step  <= 1'b1;
            end
            QD_DN: if (bus.en) begin
              r_count <= r_count - CNT_W'(1);
              r_dir   <= QD_DIR_DN;
              r_step  <= 1'b1;
            end
            QD_ILL:  r_err <= 1'b1;
            default: ;
          endcase
        end
        default: r_state <= QD_INIT;
      endcase
`ifdef QDEC_INDEX_CLR_EN
      // Placed last so an index clear overrides a coincident count step.
      r_idx_prev <= w_idx;
      if (bus.en && w_idx && !r_idx_prev) r_count <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_quad_decoder_x4.sv
// Directed self-checking bench for quad_decoder_x4 (index tests built with QDEC_INDEX_CLR_EN).
module tb_quad_decoder_x4;

  localparam int CNT_W = 16;

  logic clk;
  logic rst;
  int   checkCount;
  int   errCount;
  int   stepCnt;
  int   base;
  int   n;
  logic [1:0] upSeq [4];

  quad_decoder_x4_if #(.CNT_W(CNT_W)) bus ();

  quad_decoder_x4 #(.CNT_W(CNT_W), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.step === 1'b1) stepCnt = stepCnt + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic [1:0] ab, input int holdClks);
    @(negedge clk);
    bus.quad_a = ab[1];
    bus.quad_b = ab[0];
    repeat (holdClks) @(negedge clk);
  endtask

  task automatic applyReset(input logic [1:0] ab);
    @(negedge clk);
    rst = 1'b1;
    bus.quad_a = ab[1];
    bus.quad_b = ab[0];
    bus.en = 1'b1;
    bus.err_clr = 1'b0;
    bus.quad_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // Drives the pin change at a negedge and counts rising edges until step appears.
  task automatic measureLatency(input logic [1:0] ab);
    n = 20;
    @(negedge clk);
    bus.quad_a = ab[1];
    bus.quad_b = ab[0];
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.step === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.quad_a = 1'b0; bus.quad_b = 1'b0; bus.quad_i = 1'b0;
    bus.en = 1'b1; bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkCount++; if (bus.count !== 16'h0000) begin errCount++; $display("[TB] FAIL reset_count: got %h expected 0000", bus.count); end
    checkCount++; if (bus.dir !== 1'b0) begin errCount++; $display("[TB] FAIL reset_dir: got %b expected 0", bus.dir); end
    checkCount++; if (bus.step !== 1'b0) begin errCount++; $display("[TB] FAIL reset_step: got %b expected 0", bus.step); end
    checkCount++; if (bus.err !== 1'b0) begin errCount++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err); end
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checkCount++; if (bus.count !== 16'h0000) begin errCount++; $display("[TB] FAIL release_count: got %h expected 0000", bus.count); end
    checkCount++; if (bus.err !== 1'b0) begin errCount++; $display("[TB] FAIL release_err: got %b expected 0", bus.err); end
  endtask

  task automatic test_up_count();
    base = stepCnt;
    for (int i = 0; i < 32; i++) applyStimulus(upSeq[(i + 1) % 4], 10);
    checkCount++; if (bus.count !== 16'd32) begin errCount++; $display("[TB] FAIL up_count: got %0d expected 32", bus.count); end
    checkCount++; if (bus.dir !== 1'b0) begin errCount++; $display("[TB] FAIL up_dir: got %b expected 0", bus.dir); end
    checkCount++; if (stepCnt - base !== 32) begin errCount++; $display("[TB] FAIL up_steps: got %0d expected 32", stepCnt - base); end
  endtask

  task automatic test_latency();
    measureLatency(2'b01);
    checkCount++; if (n !== 6) begin errCount++; $display("[TB] FAIL latency: got %0d clocks expected 6", n); end
    checkCount++; if (bus.count !== 16'd33) begin errCount++; $display("[TB] FAIL latency_count: got %0d expected 33", bus.count); end
    applyStimulus(2'b00, 10);
    checkCount++; if (bus.count !== 16'd32 || bus.dir !== 1'b1) begin errCount++; $display("[TB] FAIL back_down: got count %0d dir %b expected 32/1", bus.count, bus.dir); end
  endtask

  task automatic test_down_wrap();
    applyReset(2'b00);
    base = stepCnt;
    applyStimulus(2'b10, 10);
    checkCount++; if (bus.count !== 16'hFFFF) begin errCount++; $display("[TB] FAIL wrap_count: got %h expected ffff", bus.count); end
    checkCount++; if (bus.dir !== 1'b1) begin errCount++; $display("[TB] FAIL wrap_dir: got %b expected 1", bus.dir); end
    checkCount++; if (stepCnt - base !== 1) begin errCount++; $display("[TB] FAIL wrap_steps: got %0d expected 1", stepCnt - base); end
  endtask

  task automatic test_glitch();
    base = stepCnt;
    @(negedge clk); bus.quad_a = 1'b0;
    repeat (2) @(negedge clk); bus.quad_a = 1'b1;
    repeat (12) @(negedge clk); bus.quad_b = 1'b1;
    @(negedge clk); bus.quad_b = 1'b0;
    repeat (12) @(negedge clk);
    checkCount++; if (bus.count !== 16'hFFFF) begin errCount++; $display("[TB] FAIL glitch_count: got %h expected ffff", bus.count); end
    checkCount++; if (stepCnt - base !== 0) begin errCount++; $display("[TB] FAIL glitch_steps: got %0d expected 0", stepCnt - base); end
    checkCount++; if (bus.err !== 1'b0) begin errCount++; $display("[TB] FAIL glitch_err: got %b expected 0", bus.err); end
  endtask

  task automatic test_illegal();
    applyReset(2'b00);
    applyStimulus(2'b01, 10);
    applyStimulus(2'b10, 10);
    checkCount++; if (bus.err !== 1'b1) begin errCount++; $display("[TB] FAIL illegal_err: got %b expected 1", bus.err); end
    checkCount++; if (bus.count !== 16'd1) begin errCount++; $display("[TB] FAIL illegal_count: got %0d expected 1", bus.count); end
    @(negedge clk); bus.err_clr = 1'b1;
    @(negedge clk); bus.err_clr = 1'b0;
    checkCount++; if (bus.err !== 1'b0) begin errCount++; $display("[TB] FAIL err_clr: got %b expected 0", bus.err); end
    applyStimulus(2'b00, 10);
    checkCount++; if (bus.count !== 16'd2 || bus.err !== 1'b0) begin errCount++; $display("[TB] FAIL after_clr: got count %0d err %b expected 2/0", bus.count, bus.err); end
    // The 00->11 jump is decoded on the sixth rising edge after the pin change.
    @(negedge clk);
    bus.quad_a = 1'b1; bus.quad_b = 1'b1;
    repeat (5) @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    checkCount++; if (bus.err !== 1'b1) begin errCount++; $display("[TB] FAIL set_wins: got %b expected 1", bus.err); end
    repeat (4) @(negedge clk);
    checkCount++; if (bus.count !== 16'd2) begin errCount++; $display("[TB] FAIL set_wins_count: got %0d expected 2", bus.count); end
  endtask

  task automatic test_enable();
    applyReset(2'b11);
    checkCount++; if (bus.err !== 1'b0 || bus.count !== 16'd0) begin errCount++; $display("[TB] FAIL start11: got err %b count %0d expected 0/0", bus.err, bus.count); end
    applyStimulus(2'b10, 10);
    checkCount++; if (bus.count !== 16'd1 || bus.dir !== 1'b0) begin errCount++; $display("[TB] FAIL start11_step: got count %0d dir %b expected 1/0", bus.count, bus.dir); end
    base = stepCnt;
    @(negedge clk); bus.en = 1'b0;
    applyStimulus(2'b00, 10);
    applyStimulus(2'b01, 10);
    applyStimulus(2'b11, 10);
    applyStimulus(2'b10, 10);
    checkCount++; if (bus.count !== 16'd1) begin errCount++; $display("[TB] FAIL en_hold: got %0d expected 1", bus.count); end
    checkCount++; if (stepCnt - base !== 0) begin errCount++; $display("[TB] FAIL en_steps: got %0d expected 0", stepCnt - base); end
    bus.en = 1'b1;
    repeat (10) @(negedge clk);
    checkCount++; if (stepCnt - base !== 0 || bus.count !== 16'd1) begin errCount++; $display("[TB] FAIL reenable: got steps %0d count %0d expected 0/1", stepCnt - base, bus.count); end
    applyStimulus(2'b00, 10);
    checkCount++; if (bus.count !== 16'd2) begin errCount++; $display("[TB] FAIL reenable_step: got %0d expected 2", bus.count); end
  endtask

  task automatic test_mid_reset();
    applyStimulus(2'b10, 10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkCount++; if (bus.count !== 16'd0 || bus.dir !== 1'b0 || bus.err !== 1'b0) begin errCount++; $display("[TB] FAIL mid_reset: got count %0d dir %b err %b expected 0/0/0", bus.count, bus.dir, bus.err); end
    applyReset(2'b10);
    checkCount++; if (bus.count !== 16'd0 || bus.err !== 1'b0) begin errCount++; $display("[TB] FAIL mid_reset_release: got count %0d err %b expected 0/0", bus.count, bus.err); end
  endtask

`ifdef QDEC_INDEX_CLR_EN
  task automatic test_index();
    applyReset(2'b00);
    for (int i = 0; i < 100; i++) applyStimulus(upSeq[(i + 1) % 4], 8);
    checkCount++; if (bus.count !== 16'd100) begin errCount++; $display("[TB] FAIL index_pre: got %0d expected 100", bus.count); end
    @(negedge clk);
    bus.quad_i = 1'b1;
    n = 20;
    bus.quad_a = 1'b0; bus.quad_b = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.step === 1'b1) begin
        n = k;
        break;
      end
    end
    checkCount++; if (n !== 6) begin errCount++; $display("[TB] FAIL index_latency: got %0d expected 6", n); end
    checkCount++; if (bus.count !== 16'd0 || bus.dir !== 1'b0) begin errCount++; $display("[TB] FAIL index_clear: got count %0d dir %b expected 0/0", bus.count, bus.dir); end
    @(negedge clk); bus.quad_i = 1'b0;
    repeat (10) @(negedge clk);
  endtask
`endif

  initial begin
    checkCount = 0;
    errCount   = 0;
    stepCnt    = 0;
    base       = 0;
    n          = 0;
    upSeq[0] = 2'b00; upSeq[1] = 2'b01; upSeq[2] = 2'b11; upSeq[3] = 2'b10;
    rst = 1'b1;
    bus.en = 1'b1; bus.quad_a = 1'b0; bus.quad_b = 1'b0; bus.quad_i = 1'b0; bus.err_clr = 1'b0;
    $display("[TB] starting quad_decoder_x4 bench");
    test_reset();
    test_up_count();
    test_latency();
    test_down_wrap();
    test_glitch();
    test_illegal();
    test_enable();
    test_mid_reset();
`ifdef QDEC_INDEX_CLR_EN
    test_index();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
    $finish;
  end

endmodule
